// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART message scheduler and its RX-side counterpart.
// A link word is {3-bit tag, 13-bit payload}; tag 3'b111 is reserved for keepalive.
package uart_msg_pkg;

    localparam int TAG_W  = 3;
    localparam int PAY_W  = 13;
    localparam int WORD_W = TAG_W + PAY_W;

    localparam logic [TAG_W-1:0]  KEEPALIVE_TAG  = 3'b111;
    localparam logic [WORD_W-1:0] KEEPALIVE_WORD = 16'hE000;

    typedef enum logic {
        LINK_DOWN = 1'b0,
        LINK_UP   = 1'b1
    } link_state_e;

    function automatic logic [WORD_W-1:0] mk_word(input logic [TAG_W-1:0] tag,
                                                  input logic [PAY_W-1:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping mod N.
// ptr must be < N; grant is one-hot, grant_idx its index, any = some request set.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Shares one 16-bit UART link word between N_SRC latest-value sources, round-robin,
// with keepalive filler when idle and a full flush whenever the link drops.
module uart_msg_scheduler
    import uart_msg_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   link_ok,
    input  logic                   word_taken,
    input  logic [N_SRC-1:0]       src_wr,
    input  logic [N_SRC*PAY_W-1:0] src_data,
    output logic [WORD_W-1:0]      out_word,
    output logic [N_SRC-1:0]       pending,
    output logic [TAG_W-1:0]       sent_tag,
    output logic [CNT_W-1:0]       ovf_cnt
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    link_state_e state, state_nxt;
    logic        active;

    logic [N_SRC-1:0][PAY_W-1:0] slot_data;
    logic [IDX_W-1:0]            rr_ptr;
    logic [IDX_W-1:0]            rr_nxt;
    logic [N_SRC-1:0]            grant;
    logic [IDX_W-1:0]            grant_idx;
    logic                        grant_any;
    logic [N_SRC-1:0]            grant_hit;
    logic                        ovf_hit;

    // Link FSM: state is the registered copy of link_ok
    always_ff @(posedge clk) begin
        if (rst) state <= LINK_UP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (link_ok) state_nxt = LINK_UP;
        else         state_nxt = LINK_DOWN;
    end

    // Both the registered and the live link_ok must be up; a drop flushes on the next edge
    always_comb begin
        active = 1'b0;
        if (state == LINK_UP && link_ok) active = 1'b1;
    end

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign grant_hit = (active && word_taken) ? grant : '0;
    assign rr_nxt    = (grant_idx == IDX_W'(N_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
    // A rewrite of the slot being granted this cycle is a fresh value, not an overwrite
    assign ovf_hit   = |(src_wr & pending & ~grant_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_data <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (active && src_wr[i]) slot_data[i] <= src_data[i*PAY_W +: PAY_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !active) pending <= '0;
        else                pending <= (pending & ~grant_hit) | src_wr;
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            out_word <= KEEPALIVE_WORD;
            sent_tag <= KEEPALIVE_TAG;
            rr_ptr   <= '0;
        end else if (word_taken) begin
            if (grant_any) begin
                out_word <= mk_word(TAG_W'(grant_idx), slot_data[grant_idx]);
                sent_tag <= TAG_W'(grant_idx);
                rr_ptr   <= rr_nxt;
            end else begin
                out_word <= KEEPALIVE_WORD;
                sent_tag <= KEEPALIVE_TAG;
            end
        end
    end

    // Counter survives link drops; only rst clears it
    always_ff @(posedge clk) begin
        if (rst)                                     ovf_cnt <= '0;
        else if (active && ovf_hit && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Self-checking bench: vector table, hand-written corner sequences, then random traffic
// compared against a behavioural slot/queue model.
module tb_uart_msg_scheduler;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst, link_ok, word_taken;
    logic [N-1:0]  src_wr;
    logic [N*13-1:0] src_data;
    logic [15:0]   out_word;
    logic [N-1:0]  pending;
    logic [2:0]    sent_tag;
    logic [7:0]    ovf_cnt;

    int checks = 0;
    int errors = 0;

    uart_msg_scheduler #(.N_SRC(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .link_ok(link_ok), .word_taken(word_taken),
        .src_wr(src_wr), .src_data(src_data), .out_word(out_word),
        .pending(pending), .sent_tag(sent_tag), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // behavioural model state
    int m_slot[N];
    bit m_pend[N];
    int m_rr, m_ovf, m_out, m_tag;
    bit m_up;

    typedef struct {
        bit          rst;
        logic [3:0]  wr;
        logic [12:0] d;
        bit          take;
        logic [15:0] exp_out;
        logic [3:0]  exp_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] w, logic [12:0] d, bit t,
                                logic [15:0] eo, logic [3:0] ep);
        vec_t v;
        v.rst = r; v.wr = w; v.d = d; v.take = t; v.exp_out = eo; v.exp_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int pend_vec();
        int p = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) p |= (1 << i);
        return p;
    endfunction

    task automatic model_step();
        bit old[N];
        int g;
        bit found, inc;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_slot[i] = 0; m_pend[i] = 0; end
            m_rr = 0; m_ovf = 0; m_out = 'hE000; m_tag = 7; m_up = 1;
            return;
        end
        if (!(link_ok && m_up)) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_out = 'hE000; m_tag = 7; m_rr = 0; m_up = link_ok;
            return;
        end
        found = 0; g = 0;
        for (int k = 0; k < N; k++)
            if (!found && m_pend[(m_rr + k) % N]) begin found = 1; g = (m_rr + k) % N; end
        old = m_pend;
        if (word_taken) begin
            if (found) begin
                m_out = (g << 13) | m_slot[g];
                m_tag = g; m_pend[g] = 0; m_rr = (g + 1) % N;
            end else begin
                m_out = 'hE000; m_tag = 7;
            end
        end
        inc = 0;
        for (int i = 0; i < N; i++) begin
            if (src_wr[i]) begin
                if (old[i] && !(word_taken && found && i == g)) inc = 1;
                m_slot[i] = int'(src_data[i*13 +: 13]);
                m_pend[i] = 1;
            end
        end
        if (inc && m_ovf < 255) m_ovf++;
        m_up = link_ok;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; link_ok = 1'b1; word_taken = 1'b0; src_wr = '0;
    endtask

    task automatic wr(input int i, input int d);
        logic [12:0] p;
        p = d[12:0];
        src_wr[i] = 1'b1;
        src_data[i*13 +: 13] = p;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; tick(); idle();
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " out_word"}, int'(out_word), m_out);
        chk({tag, " pending"},  int'(pending),  pend_vec());
        chk({tag, " sent_tag"}, int'(sent_tag), m_tag);
        chk({tag, " ovf_cnt"},  int'(ovf_cnt),  m_ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        src_data = '0;
        do_reset();
        chk("reset out_word", int'(out_word), 'hE000);
        chk("reset pending",  int'(pending),  0);
        chk("reset sent_tag", int'(sent_tag), 7);
        chk("reset ovf_cnt",  int'(ovf_cnt),  0);

        // idle takes, single source, then 4-source round robin with rewrites
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b0000, 13'h0, 1, 16'hE000, 4'b0000));
        vecs.push_back(mk(1, 4'b0000, 13'h0,    0, 16'hE000, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 13'h0ABC, 0, 16'hE000, 4'b0010));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h2ABC, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'hE000, 4'b0000));
        vecs.push_back(mk(1, 4'b0000, 13'h0,    0, 16'hE000, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 13'h0100, 0, 16'hE000, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h0100, 4'b1110));
        vecs.push_back(mk(0, 4'b0001, 13'h0101, 0, 16'h0100, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h2100, 4'b1101));
        vecs.push_back(mk(0, 4'b0010, 13'h0102, 0, 16'h2100, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h4100, 4'b1011));
        vecs.push_back(mk(0, 4'b0100, 13'h0103, 0, 16'h4100, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h6100, 4'b0111));
        vecs.push_back(mk(0, 4'b1000, 13'h0104, 0, 16'h6100, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h0101, 4'b1110));
        vecs.push_back(mk(0, 4'b0001, 13'h0105, 0, 16'h0101, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h2102, 4'b1101));
        vecs.push_back(mk(0, 4'b0010, 13'h0106, 0, 16'h2102, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h4103, 4'b1011));
        vecs.push_back(mk(0, 4'b0100, 13'h0107, 0, 16'h4103, 4'b1111));
        vecs.push_back(mk(0, 4'b0000, 13'h0,    1, 16'h6104, 4'b0111));

        foreach (vecs[n]) begin
            idle();
            rst = vecs[n].rst; word_taken = vecs[n].take; src_wr = vecs[n].wr;
            for (int i = 0; i < N; i++) if (vecs[n].wr[i]) wr(i, int'(vecs[n].d));
            tick();
            idle();
            chk($sformatf("vec%0d out_word", n), int'(out_word), int'(vecs[n].exp_out));
            chk($sformatf("vec%0d pending", n),  int'(pending),  int'(vecs[n].exp_pend));
            chk($sformatf("vec%0d sent_tag", n), int'(sent_tag), int'(vecs[n].exp_out[15:13]));
            chk($sformatf("vec%0d ovf_cnt", n),  int'(ovf_cnt),  0);
        end

        // overwrite counting and saturation
        do_reset();
        wr(2, 'h11); tick(); idle();
        wr(2, 'h22); tick(); idle();
        chk("ovf one", int'(ovf_cnt), 1);
        word_taken = 1'b1; tick(); idle();
        chk("ovf latest value", int'(out_word), 'h4022);
        chk("ovf after take", int'(ovf_cnt), 1);
        for (int k = 0; k < 300; k++) begin wr(0, k); tick(); end
        idle();
        chk("ovf saturate", int'(ovf_cnt), 'hFF);
        wr(0, 1); tick(); idle();
        chk("ovf no wrap", int'(ovf_cnt), 'hFF);

        // write to the slot granted in the same cycle
        do_reset();
        wr(0, 1); tick(); idle();
        word_taken = 1'b1; wr(0, 2); tick(); idle();
        chk("same-cycle old data", int'(out_word), 'h0001);
        chk("same-cycle pending",  int'(pending),  'b0001);
        chk("same-cycle no ovf",   int'(ovf_cnt),  0);
        word_taken = 1'b1; tick(); idle();
        chk("same-cycle new data", int'(out_word), 'h0002);
        chk("same-cycle drained",  int'(pending),  0);

        // link drop: flush, ignore writes, rr_ptr back to 0, ovf kept
        do_reset();
        wr(1, 'h0AA); tick(); idle();
        word_taken = 1'b1; tick(); idle();
        chk("drop pre word", int'(out_word), 'h20AA);
        wr(3, 5); tick(); idle();
        wr(3, 6); tick(); idle();
        chk("drop pre ovf", int'(ovf_cnt), 1);
        link_ok = 1'b0; word_taken = 1'b1; wr(1, 'h077); tick(); idle();
        chk("drop pending",  int'(pending),  0);
        chk("drop out_word", int'(out_word), 'hE000);
        chk("drop sent_tag", int'(sent_tag), 7);
        chk("drop ovf kept", int'(ovf_cnt),  1);
        tick();
        wr(1, 'h0B1); wr(2, 'h0B2); tick(); idle();
        word_taken = 1'b1; tick(); idle();
        chk("drop rr reset", int'(out_word), 'h20B1);
        word_taken = 1'b1; tick(); idle();
        chk("drop rr next", int'(out_word), 'h40B2);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            link_ok    = ($urandom_range(0, 39) != 0);
            word_taken = $urandom_range(0, 1) == 1;
            src_wr     = N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++) begin
                logic [12:0] p;
                p = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom);
                src_data[i*13 +: 13] = p;
            end
            tick();
            cmp_model($sformatf("rand%0d", c));
            if (out_word[15:13] == 3'b111)
                chk($sformatf("rand%0d keyword", c), int'(out_word[12:0]), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
